// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C slave protocol controller.
package i2c_pkg;
   typedef enum logic [2:0] {
      IDLE, ADDR, ACK_ADDR, RX_BYTE, ACK_RX, TX_BYTE, CHK_ACK, WAIT_STOP
   } state_t;

   localparam int         BITS_PER_BYTE = 8;
   localparam logic [6:0] GENCALL_ADDR  = 7'h00;
endpackage

// File: rtl/i2c_shift8.sv
// 8-bit shifter: serial-in (LSB side) shift, parallel load, MSB serial-out.
module i2c_shift8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       shift_en_i,
   input  logic       sin_i,
   input  logic       load_en_i,
   input  logic [7:0] load_data_i,
   output logic [7:0] q_o,
   output logic       sout_o
);
   logic [7:0] sh_q;

   always_ff @(posedge clk) begin
      if (rst)             sh_q <= '0;
      else if (load_en_i)  sh_q <= load_data_i;
      else if (shift_en_i) sh_q <= {sh_q[6:0], sin_i};
   end

   assign q_o    = sh_q;
   assign sout_o = sh_q[7];
endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave protocol controller: address match, byte RX/TX, ACK handling.
// Optional general-call support is enabled with `define I2C_GENCALL_EN.
module i2c_slave_ctrl
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR   = 7'h78,
   parameter logic [7:0] IDLE_TX_BYTE = 8'hFF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rising_edge_found,
   input  logic       falling_edge_found,
   input  logic       start_found,
   input  logic       stop_found,
   input  logic       sda_in,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   input  logic       rx_full,
   output logic       sda_oe,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       tx_ack,
   output logic       tx_underrun,
   output logic       busy
`ifdef I2C_GENCALL_EN
   ,output logic      gen_call
`endif
);
   localparam logic [3:0] CNT_FULL = 4'(BITS_PER_BYTE);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       rw_q, rw_d, dlv_q, dlv_d, sda_oe_q, sda_oe_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d, tx_ack_q, tx_ack_d, tx_und_q, tx_und_d;
   logic       gc_q, gc_d;
   logic       rise, fall, cnt_full, addr_hit, gc_hit;
   logic       sh_shift, sh_load, sh_msb, do_load;
   logic [7:0] sh_q, tx_byte;

   i2c_shift8 u_shift (
      .clk         (clk),
      .rst         (rst),
      .shift_en_i  (sh_shift),
      .sin_i       (sda_in),
      .load_en_i   (sh_load),
      .load_data_i (tx_byte),
      .q_o         (sh_q),
      .sout_o      (sh_msb)
   );

   // Coincident strobes are contradictory and dropped.
   assign rise     = rising_edge_found & ~falling_edge_found;
   assign fall     = falling_edge_found & ~rising_edge_found;
   assign cnt_full = (cnt_q == CNT_FULL);
   assign tx_byte  = tx_valid ? tx_data : IDLE_TX_BYTE;
`ifdef I2C_GENCALL_EN
   assign gc_hit   = (sh_q[7:1] == GENCALL_ADDR) & ~sh_q[0];
`else
   assign gc_hit   = 1'b0;
`endif
   assign addr_hit = (sh_q[7:1] == SLAVE_ADDR) | gc_hit;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rw_d       = rw_q;
      dlv_d      = dlv_q;
      sda_oe_d   = sda_oe_q;
      rx_data_d  = rx_data_q;
      gc_d       = gc_q;
      rx_valid_d = 1'b0;
      tx_ack_d   = 1'b0;
      tx_und_d   = 1'b0;
      sh_shift   = 1'b0;
      do_load    = 1'b0;
      if (stop_found || start_found) begin
         state_d  = stop_found ? IDLE : ADDR;
         cnt_d    = '0;
         dlv_d    = 1'b0;
         sda_oe_d = 1'b0;
         gc_d     = 1'b0;
      end else begin
         case (state_q)
            ADDR: begin
               if (rise && !cnt_full) begin
                  sh_shift = 1'b1;
                  cnt_d    = cnt_q + 4'd1;
               end else if (cnt_full && !addr_hit) begin
                  state_d = WAIT_STOP;
                  cnt_d   = '0;
               end else if (cnt_full && fall) begin
                  state_d  = ACK_ADDR;
                  cnt_d    = '0;
                  rw_d     = sh_q[0];
                  sda_oe_d = 1'b1;
                  gc_d     = gc_hit;
               end
            end
            ACK_ADDR: if (fall) begin
               cnt_d = '0;
               if (rw_q) begin
                  state_d = TX_BYTE;
                  do_load = 1'b1;
               end else begin
                  state_d  = RX_BYTE;
                  sda_oe_d = 1'b0;
               end
            end
            RX_BYTE: begin
               if (rise && !cnt_full) begin
                  sh_shift = 1'b1;
                  cnt_d    = cnt_q + 4'd1;
               end else if (cnt_full && !dlv_q) begin
                  // dlv_q limits delivery to one strobe per byte while awaiting the ACK edge
                  rx_data_d  = sh_q;
                  rx_valid_d = 1'b1;
                  if (rx_full) begin
                     state_d = WAIT_STOP;
                     cnt_d   = '0;
                  end else if (fall) begin
                     state_d  = ACK_RX;
                     cnt_d    = '0;
                     sda_oe_d = 1'b1;
                  end else begin
                     dlv_d = 1'b1;
                  end
               end else if (cnt_full && fall) begin
                  state_d  = ACK_RX;
                  cnt_d    = '0;
                  dlv_d    = 1'b0;
                  sda_oe_d = 1'b1;
               end
            end
            ACK_RX: if (fall) begin
               state_d  = RX_BYTE;
               cnt_d    = '0;
               sda_oe_d = 1'b0;
            end
            TX_BYTE: begin
               // Shift on the master's sample edge so the next bit sits at the MSB for the fall.
               if (rise && !cnt_full) begin
                  sh_shift = 1'b1;
                  cnt_d    = cnt_q + 4'd1;
               end else if (fall && cnt_full) begin
                  state_d  = CHK_ACK;
                  cnt_d    = '0;
                  sda_oe_d = 1'b0;
               end else if (fall && cnt_q != '0) begin
                  sda_oe_d = ~sh_msb;
               end
            end
            CHK_ACK: begin
               if (rise && sda_in) begin
                  state_d = WAIT_STOP;
                  cnt_d   = '0;
               end else if (rise) begin
                  cnt_d = 4'd1;
               end else if (fall && cnt_q == 4'd1) begin
                  state_d = TX_BYTE;
                  cnt_d   = '0;
                  do_load = 1'b1;
               end
            end
            default: ;
         endcase
      end
      sh_load = do_load;
      if (do_load) begin
         sda_oe_d = ~tx_byte[7];
         tx_ack_d = tx_valid;
         tx_und_d = ~tx_valid;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rw_q       <= 1'b0;
         dlv_q      <= 1'b0;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_ack_q   <= 1'b0;
         tx_und_q   <= 1'b0;
         gc_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rw_q       <= rw_d;
         dlv_q      <= dlv_d;
         sda_oe_q   <= sda_oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_ack_q   <= tx_ack_d;
         tx_und_q   <= tx_und_d;
         gc_q       <= gc_d;
      end
   end

   assign sda_oe      = sda_oe_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
   assign tx_ack      = tx_ack_q;
   assign tx_underrun = tx_und_q;
   assign busy        = (state_q != IDLE);
`ifdef I2C_GENCALL_EN
   assign gen_call    = gc_q;
`else
   logic unused_gc;
   assign unused_gc   = gc_q;
`endif
endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Randomized master-side bench for i2c_slave_ctrl with a transaction-level reference model.
module tb_i2c_slave_ctrl;
   logic       clk = 1'b0;
   logic       rst, rising_edge_found, falling_edge_found, start_found, stop_found;
   logic       sda_in, tx_valid, rx_full;
   logic [7:0] tx_data;
   logic       sda_oe, rx_valid, tx_ack, tx_underrun, busy;
   logic [7:0] rx_data;
`ifdef I2C_GENCALL_EN
   logic       gen_call;
   localparam bit GC = 1'b1;
`else
   localparam bit GC = 1'b0;
`endif

   int n_vec = 0, n_err = 0;
   int rxv_cnt = 0, txa_cnt = 0, und_cnt = 0, oe_cnt = 0;
   logic [7:0] rxq[$];
   int rx_rd = 0;

   logic [7:0] wd[5], td[5];
   logic       wf[5], tv[5], ma[5];

   i2c_slave_ctrl dut (
      .clk                (clk),
      .rst                (rst),
      .rising_edge_found  (rising_edge_found),
      .falling_edge_found (falling_edge_found),
      .start_found        (start_found),
      .stop_found         (stop_found),
      .sda_in             (sda_in),
      .tx_data            (tx_data),
      .tx_valid           (tx_valid),
      .rx_full            (rx_full),
      .sda_oe             (sda_oe),
      .rx_data            (rx_data),
      .rx_valid           (rx_valid),
      .tx_ack             (tx_ack),
      .tx_underrun        (tx_underrun),
      .busy               (busy)
`ifdef I2C_GENCALL_EN
      ,.gen_call          (gen_call)
`endif
   );

   always #5 clk = ~clk;

   // Host-side monitor: records every strobe cycle and delivered byte.
   always @(negedge clk) begin
      if (rx_valid) begin
         rxv_cnt++;
         rxq.push_back(rx_data);
      end
      if (tx_ack)      txa_cnt++;
      if (tx_underrun) und_cnt++;
      if (sda_oe)      oe_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference rule: which address bytes the slave acknowledges.
   function automatic logic addr_hit(input logic [6:0] a, input logic rw);
      return (a == 7'h78) || (GC && a == 7'h00 && !rw);
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic scl_bit(input logic b, output logic oe);
      sda_in = b;
      idle(2);
      rising_edge_found = 1'b1;
      @(negedge clk);
      rising_edge_found = 1'b0;
      idle(3);
      oe = sda_oe;
      falling_edge_found = 1'b1;
      @(negedge clk);
      falling_edge_found = 1'b0;
      idle(1);
   endtask

   task automatic start_cond();
      start_found = 1'b1;
      @(negedge clk);
      start_found = 1'b0;
      idle(1);
      falling_edge_found = 1'b1;
      @(negedge clk);
      falling_edge_found = 1'b0;
      idle(1);
   endtask

   task automatic stop_cond();
      stop_found = 1'b1;
      @(negedge clk);
      stop_found = 1'b0;
      idle(2);
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack, output logic drv);
      logic oe;
      drv = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         scl_bit(d[i], oe);
         drv = drv | oe;
      end
      scl_bit(1'b1, ack);
   endtask

   task automatic rd_byte(input logic mack, input logic nv, input logic [7:0] nd,
                          output logic [7:0] d, output logic oe9);
      logic oe;
      for (int i = 7; i >= 0; i--) begin
         scl_bit(1'b1, oe);
         d[i] = ~oe;
      end
      tx_valid = nv;
      tx_data  = nd;
      scl_bit(~mack, oe9);
   endtask

   task automatic run_txn(input logic [6:0] a, input logic rw, input int n);
      logic hit, ack, drv, alive, oe9;
      logic [7:0] d;
      logic [7:0] exq[$];
      int rxv0, txa0, und0, oe0, etxa, eund;
      hit  = addr_hit(a, rw);
      rxv0 = rxv_cnt; txa0 = txa_cnt; und0 = und_cnt; oe0 = oe_cnt;
      etxa = 0; eund = 0;
      tx_valid = tv[0];
      tx_data  = td[0];
      rx_full  = 1'b0;
      start_cond();
      check("busy_mid", busy, 1);
      wr_byte({a, rw}, ack, drv);
      check("addr_ack", ack, hit);
      check("addr_nodrv", drv, 0);
`ifdef I2C_GENCALL_EN
      check("gen_call", gen_call, hit && a == 7'h00);
`endif
      if (!rw) begin
         alive = hit;
         for (int i = 0; i < n; i++) begin
            rx_full = wf[i];
            wr_byte(wd[i], ack, drv);
            check("wr_ack", ack, alive && !wf[i]);
            check("wr_nodrv", drv, 0);
            if (alive) exq.push_back(wd[i]);
            alive = alive && !wf[i];
         end
      end else if (hit) begin
         for (int i = 0; i < n; i++) begin
            rd_byte(ma[i], tv[i+1], td[i+1], d, oe9);
            check("rd_data", d, tv[i] ? td[i] : 8'hFF);
            check("rd_rel9", oe9, 0);
            if (tv[i]) etxa++; else eund++;
            if (!ma[i]) break;
         end
         check("rd_released", sda_oe, 0);
      end
      stop_cond();
      check("busy_idle", busy, 0);
      check("oe_idle", sda_oe, 0);
`ifdef I2C_GENCALL_EN
      check("gen_call_clr", gen_call, 0);
`endif
      check("rx_valid_cnt", rxv_cnt - rxv0, exq.size());
      foreach (exq[k]) begin
         check("rx_data", (rx_rd < rxq.size()) ? rxq[rx_rd] : 8'hxx, exq[k]);
         rx_rd++;
      end
      rx_rd = rxq.size();
      check("tx_ack_cnt", txa_cnt - txa0, etxa);
      check("tx_under_cnt", und_cnt - und0, eund);
      if (!hit) check("no_drive", oe_cnt - oe0, 0);
   endtask

   initial begin
      logic ack, drv, oe;
      logic [6:0] a;
      int n;
      rst = 1'b1;
      rising_edge_found = 1'b0; falling_edge_found = 1'b0;
      start_found = 1'b0; stop_found = 1'b0;
      sda_in = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; rx_full = 1'b0;
      idle(3);
      rst = 1'b0;
      idle(1);
      check("rst_oe", sda_oe, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_tx_ack", tx_ack, 0);
      check("rst_tx_under", tx_underrun, 0);
      check("rst_busy", busy, 0);
`ifdef I2C_GENCALL_EN
      check("rst_gen_call", gen_call, 0);
`endif

      // Write 0xA5
      wd[0] = 8'hA5; wf[0] = 1'b0;
      run_txn(7'h78, 1'b0, 1);
      // Address mismatch followed by a data byte
      wd[0] = 8'h3C; wf[0] = 1'b0;
      run_txn(7'h50, 1'b0, 1);
      // Read: valid 0xC3 with master ACK, then underrun with master NACK
      tv[0] = 1'b1; td[0] = 8'hC3; ma[0] = 1'b1;
      tv[1] = 1'b0; td[1] = 8'h00; ma[1] = 1'b0;
      tv[2] = 1'b0; td[2] = 8'h00;
      run_txn(7'h78, 1'b1, 2);
      // Receive overflow, later byte ignored
      wd[0] = 8'h11; wf[0] = 1'b1;
      wd[1] = 8'h22; wf[1] = 1'b0;
      run_txn(7'h78, 1'b0, 2);
      // General-call address
      wd[0] = 8'h33; wf[0] = 1'b0;
      run_txn(7'h00, 1'b0, 1);
      tv[0] = 1'b1; td[0] = 8'h44; tv[1] = 1'b0; ma[0] = 1'b0;
      run_txn(7'h00, 1'b1, 1);

      // Repeated START after 4 data bits, then a fresh write
      begin
         int r0;
         r0 = rxv_cnt;
         rx_full = 1'b0;
         start_cond();
         wr_byte(8'hF0, ack, drv);
         check("rs_addr1_ack", ack, 1);
         for (int i = 0; i < 4; i++) scl_bit(i[0], oe);
         start_cond();
         check("rs_busy", busy, 1);
         wr_byte(8'hF0, ack, drv);
         check("rs_addr2_ack", ack, 1);
         wr_byte(8'h5A, ack, drv);
         check("rs_data_ack", ack, 1);
         stop_cond();
         check("rs_rx_cnt", rxv_cnt - r0, 1);
         check("rs_rx_data", (rx_rd < rxq.size()) ? rxq[rx_rd] : 8'hxx, 8'h5A);
         rx_rd = rxq.size();
      end

      // Reset while the address ACK is being driven
      start_cond();
      for (int i = 7; i >= 0; i--) scl_bit(i == 0 ? 1'b0 : (8'hF0 >> i) & 1'b1, oe);
      check("ackaddr_oe", sda_oe, 1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_oe", sda_oe, 0);
      check("rst_mid_busy", busy, 0);
      rst = 1'b0;
      idle(2);

      // Randomized transactions
      for (int t = 0; t < 40; t++) begin
         case ($urandom_range(3))
            0, 1: a = 7'h78;
            2:    a = 7'($urandom);
            default: a = 7'h00;
         endcase
         n = $urandom_range(1, 3);
         for (int i = 0; i < 5; i++) begin
            wd[i] = 8'($urandom);
            wf[i] = ($urandom_range(4) == 0);
            tv[i] = ($urandom_range(3) != 0);
            td[i] = 8'($urandom);
            ma[i] = (i < n - 1) ? ($urandom_range(3) != 0) : 1'b0;
         end
         run_txn(a, 1'($urandom), n);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
